// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake of the buffered UART transmitter: a producer pushes bytes
// with valid/ready, and the transmitter reports whether its FIFO has room.
interface uart_tx_buffered_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_TX_Data;
  logic             i_TX_Valid;
  logic             o_TX_Ready;

  modport master (
    output i_TX_Data,
    output i_TX_Valid,
    input  o_TX_Ready
  );

  modport slave (
    input  i_TX_Data,
    input  i_TX_Valid,
    output o_TX_Ready
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a DEPTH-entry FIFO and are sent
// LSB-first, back-to-back, with one idle bit-less cycle between queued frames.
module uart_tx_buffered #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200,
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_buffered_if.slave        tx,
  output logic [$clog2(DEPTH):0]   o_FIFO_Count,
  output logic                     o_TX_Serial,
  output logic                     o_TX_Active,
  output logic                     o_TX_Done
);

  localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W      = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   BIT_LAST   = IDX_W'(WIDTH - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [WIDTH-1:0]   shift_reg;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               push;
  logic               pop;
  logic               baud_last;

  // Ready is derived from the registered count, so a push while full is simply
  // never accepted, even if the FSM pops in that same cycle.
  assign tx.o_TX_Ready = (o_FIFO_Count != FULL_COUNT);
  assign push          = tx.i_TX_Valid && tx.o_TX_Ready;
  assign pop           = (state == S_IDLE) && (o_FIFO_Count != '0);
  assign baud_last     = (baud_cnt == BAUD_LAST);

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so clearing the array would only cost reset fan-out with no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx.i_TX_Data;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_FIFO_Count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   o_FIFO_Count <= o_FIFO_Count + COUNT_W'(1);
        2'b01:   o_FIFO_Count <= o_FIFO_Count - COUNT_W'(1);
        default: o_FIFO_Count <= o_FIFO_Count;
      endcase
    end
  end

  // Line outputs are registered from the current state, so the line trails the
  // state by one cycle; Done is aligned to the last stop-bit cycle on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          baud_cnt    <= '0;
          bit_idx     <= '0;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            state     <= S_START;
          end
        end

        S_START: begin
          o_TX_Serial <= 1'b0;
          o_TX_Active <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          o_TX_Serial <= shift_reg[bit_idx];
          o_TX_Active <= 1'b1;
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b1;
          if (baud_last) begin
            baud_cnt  <= '0;
            o_TX_Done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at default parameters (434 clocks per bit):
// reset, latency, single and back-to-back frames, overflow, mid-frame reset, loopback.
module tb_uart_tx_buffered;

  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_count;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_total   = 0;

  logic [7:0] stim [6];
  int         n_stim;
  int         exp_accept;
  int         exp_count_after;

  uart_tx_buffered_if #(.WIDTH(8)) tx_if ();

  uart_tx_buffered #(
    .FPGA_clk_freq(50000000),
    .baudrate     (115200),
    .WIDTH        (8),
    .DEPTH        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx_if.slave),
    .o_FIFO_Count(fifo_count),
    .o_TX_Serial (tx_serial),
    .o_TX_Active (tx_active),
    .o_TX_Done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_total <= done_total + 1;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Drives stim[0..n_stim-1] on consecutive edges, checking Ready before each one.
  task automatic push_stim();
    logic exp_rdy;
    for (int i = 0; i < n_stim; i++) begin
      exp_rdy = (i < exp_accept);
      tests_run++;
      if (tx_if.o_TX_Ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL push%0d_ready: got %b expected %b", i, tx_if.o_TX_Ready, exp_rdy);
      end
      tx_if.i_TX_Data  = stim[i];
      tx_if.i_TX_Valid = 1'b1;
      @(negedge clk);
    end
    tx_if.i_TX_Valid = 1'b0;
    tests_run++;
    if (fifo_count !== 3'(exp_count_after)) begin
      tests_failed++;
      $display("FAIL count_after_push: got %0d expected %0d", fifo_count, exp_count_after);
    end
  endtask

  // Checks one whole frame cycle by cycle; on return the current negedge is the
  // last stop-bit cycle.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [9:0] line;
    int         n;
    int         errs;
    logic       bad_val;
    int         done_at;
    int         done_hits;
    int         act_hits;
    line = {1'b1, b, 1'b0};
    n = 0;
    while (tx_serial !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (tx_serial !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_start: line %b after %0d cycles, expected start bit 0", tag, tx_serial, n);
      return;
    end
    done_at   = -1;
    done_hits = 0;
    act_hits  = 0;
    for (int bi = 0; bi < 10; bi++) begin
      errs    = 0;
      bad_val = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (!(bi == 0 && c == 0)) @(negedge clk);
        if (tx_serial !== line[bi]) begin
          if (errs == 0) bad_val = tx_serial;
          errs++;
        end
        if (tx_done === 1'b1) begin
          done_hits++;
          done_at = bi * CPB + c;
        end
        if (tx_active === 1'b1) act_hits++;
      end
      tests_run++;
      if (errs != 0) begin
        tests_failed++;
        $display("FAIL %s_bit%0d: line %b on %0d cycles, expected %b", tag, bi, bad_val, errs, line[bi]);
      end
    end
    tests_run++;
    if (done_hits != 1 || done_at != FRAME - 1) begin
      tests_failed++;
      $display("FAIL %s_done: %0d pulses, last at cycle %0d, expected 1 pulse at %0d",
               tag, done_hits, done_at, FRAME - 1);
    end
    tests_run++;
    if (act_hits != FRAME) begin
      tests_failed++;
      $display("FAIL %s_active: high %0d cycles, expected %0d", tag, act_hits, FRAME);
    end
  endtask

  // Independent receiver: samples mid-bit after detecting the falling start edge.
  task automatic rx_byte(output logic [7:0] b, output logic frame_ok, output logic got);
    int n;
    n        = 0;
    b        = '0;
    frame_ok = 1'b0;
    got      = 1'b0;
    while (tx_serial !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tx_serial !== 1'b0) return;
    got = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    frame_ok = (tx_serial === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx_serial;
    end
    repeat (CPB) @(negedge clk);
    frame_ok = frame_ok && (tx_serial === 1'b1);
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    int         errs;
    int         done_snap;
    rst              = 1'b1;
    tx_if.i_TX_Data  = 8'h00;
    tx_if.i_TX_Valid = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {tx_serial, tx_if.o_TX_Ready, fifo_count, tx_active, tx_done};
      tests_run++;
      if (obs !== 7'b1_1_000_0_0) begin
        tests_failed++;
        $display("FAIL reset_hold%0d: {ser,rdy,cnt,act,done}=%b expected 1100000", i, obs);
      end
    end
    rst = 1'b1;
    done_snap = done_total;
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    n_stim = 3; exp_accept = 3; exp_count_after = 2;
    push_stim();
    repeat (100) @(negedge clk);
    tests_run++;
    if ({tx_active, fifo_count} !== {1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL reset_pre_abort: active=%b count=%0d expected 1 and 2", tx_active, fifo_count);
    end
    #2 rst = 1'b0;
    #1;
    obs = {tx_serial, tx_if.o_TX_Ready, fifo_count, tx_active, tx_done};
    tests_run++;
    if (obs !== 7'b1_1_000_0_0) begin
      tests_failed++;
      $display("FAIL reset_async: {ser,rdy,cnt,act,done}=%b expected 1100000", obs);
    end
    @(negedge clk);
    rst  = 1'b1;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0 || done_total != done_snap) begin
      tests_failed++;
      $display("FAIL reset_after: %0d busy cycles, %0d done pulses, expected 0 and 0",
               errs, done_total - done_snap);
    end
  endtask

  task automatic test_single();
    int done_snap;
    done_snap = done_total;
    tx_if.i_TX_Data  = 8'h37;
    tx_if.i_TX_Valid = 1'b1;
    @(negedge clk);
    tx_if.i_TX_Valid = 1'b0;
    tx_if.i_TX_Data  = 8'hC3;
    tests_run++;
    if ({fifo_count, tx_serial} !== {3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL lat_n: count=%0d ser=%b expected 1 and 1", fifo_count, tx_serial);
    end
    @(negedge clk);
    tests_run++;
    if ({fifo_count, tx_serial, tx_active} !== {3'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lat_n1: count=%0d ser=%b act=%b expected 0,1,0", fifo_count, tx_serial, tx_active);
    end
    @(negedge clk);
    tests_run++;
    if ({tx_serial, tx_active} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lat_n2: ser=%b act=%b expected 0,1", tx_serial, tx_active);
    end
    expect_frame(8'h37, "single");
    @(negedge clk);
    tests_run++;
    if ({tx_serial, tx_active, fifo_count} !== {1'b1, 1'b0, 3'd0} || done_total - done_snap != 1) begin
      tests_failed++;
      $display("FAIL single_end: ser=%b act=%b count=%0d pulses=%0d expected 1,0,0,1",
               tx_serial, tx_active, fifo_count, done_total - done_snap);
    end
  endtask

  task automatic run_queue(input int frames, input string tag);
    for (int k = 0; k < frames; k++) begin
      expect_frame(stim[k], $sformatf("%s%0d", tag, k));
      @(negedge clk);
      tests_run++;
      if ({tx_serial, tx_active} !== 2'b10) begin
        tests_failed++;
        $display("FAIL %s%0d_idle: ser=%b act=%b expected 1,0", tag, k, tx_serial, tx_active);
      end
      if (k < frames - 1) begin
        @(negedge clk);
        tests_run++;
        if (tx_serial !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s%0d_gap: line %b after one idle cycle, expected 0", tag, k, tx_serial);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_snap;
    done_snap = done_total;
    stim[0] = 8'h37; stim[1] = 8'h38; stim[2] = 8'h39; stim[3] = 8'h40;
    n_stim = 4; exp_accept = 4; exp_count_after = 3;
    fork
      push_stim();
    join_none
    run_queue(4, "b2b");
    tests_run++;
    if (done_total - done_snap != 4 || fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL b2b_end: pulses=%0d count=%0d expected 4 and 0", done_total - done_snap, fifo_count);
    end
  endtask

  task automatic test_overflow();
    int errs;
    int done_snap;
    done_snap = done_total;
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
    n_stim = 6; exp_accept = 5; exp_count_after = 4;
    fork
      push_stim();
    join_none
    run_queue(5, "ovf");
    errs = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0 || fifo_count !== 3'd0 || tx_if.o_TX_Ready !== 1'b1 || done_total - done_snap != 5) begin
      tests_failed++;
      $display("FAIL ovf_dropped: busy=%0d count=%0d rdy=%b pulses=%0d expected 0,0,1,5",
               errs, fifo_count, tx_if.o_TX_Ready, done_total - done_snap);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int errs;
    int done_snap;
    done_snap = done_total;
    tx_if.i_TX_Data  = 8'hA5;
    tx_if.i_TX_Valid = 1'b1;
    @(negedge clk);
    tx_if.i_TX_Valid = 1'b0;
    n = 0;
    while (tx_serial !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3 * CPB + 100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({tx_serial, tx_active, tx_done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_async: ser=%b act=%b done=%b expected 1,0,0", tx_serial, tx_active, tx_done);
    end
    errs = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) errs++;
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) errs++;
    end
    tests_run++;
    if (errs != 0 || done_total != done_snap) begin
      tests_failed++;
      $display("FAIL abort_quiet: low cycles=%0d pulses=%0d expected 0 and 0", errs, done_total - done_snap);
    end
    tx_if.i_TX_Data  = 8'h3C;
    tx_if.i_TX_Valid = 1'b1;
    @(negedge clk);
    tx_if.i_TX_Valid = 1'b0;
    expect_frame(8'h3C, "post_abort");
    @(negedge clk);
    tests_run++;
    if (done_total - done_snap != 1) begin
      tests_failed++;
      $display("FAIL abort_done_total: %0d pulses expected 1", done_total - done_snap);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    logic       ok;
    logic       got;
    stim[0] = 8'h00; stim[1] = 8'hFF; stim[2] = 8'h55;
    n_stim = 3; exp_accept = 3; exp_count_after = 2;
    fork
      push_stim();
    join_none
    for (int k = 0; k < 3; k++) begin
      rx_byte(b, ok, got);
      tests_run++;
      if (got !== 1'b1 || ok !== 1'b1 || b !== stim[k]) begin
        tests_failed++;
        $display("FAIL loop%0d: got=%b framing_ok=%b byte=%h expected byte %h", k, got, ok, b, stim[k]);
      end
    end
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
